// File: rtl/order_msg_buffer.sv
// order_msg_buffer
//   Assembles a byte-serial order feed into fixed-size messages and queues
//   complete messages in a small first-word-fall-through FIFO for the parser.
//   Short or long messages are dropped, flagged on len_err and counted.
//
// Ports
//   clk              : clock, rising edge
//   resetn           : asynchronous active-low reset
//   byte_valid       : feed byte present on byte_data
//   byte_data[7:0]   : feed byte, first byte of a message is the MSB byte
//   byte_last        : presented byte ends a message
//   byte_ready       : byte accepted this cycle (FIFO not full)
//   pop              : consume the head message (ignored while empty)
//   buffer_not_empty : at least one complete message stored
//   ff_buffer        : head message, byte 0 in the top byte
//   len_err          : one-cycle pulse when a malformed message is dropped
//   drop_count[7:0]  : saturating count of dropped messages
`timescale 1ns/1ps
module order_msg_buffer #(
    parameter int DEPTH     = 4,
    parameter int MSG_BYTES = 40
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    input  logic                   byte_last,
    output logic                   byte_ready,
    input  logic                   pop,
    output logic                   buffer_not_empty,
    output logic [MSG_BYTES*8-1:0] ff_buffer,
    output logic                   len_err,
    output logic [7:0]             drop_count
);

    localparam int MSG_BITS = MSG_BYTES * 8;
    localparam int AW       = $clog2(DEPTH);
    localparam int IW       = $clog2(MSG_BYTES);

    localparam logic [IW-1:0] LAST_IDX = IW'(MSG_BYTES - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_DISCARD = 1'b1;

    logic [0:0]          state;
    logic [IW-1:0]       idx;
    logic [MSG_BITS-1:0] asm_msg;
    logic [MSG_BITS-1:0] mem [DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;

    logic                full;
    logic                empty;
    logic                accept;
    logic                collecting;
    logic                at_last_slot;
    logic                complete;
    logic                drop;
    logic                do_pop;
    logic [MSG_BITS-1:0] wr_data;

    // Pointers carry an extra wrap bit: equal addresses with differing wrap
    // bits mean full, fully equal pointers mean empty.
    always_comb begin
        empty        = (wr_ptr == rd_ptr);
        full         = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        accept       = byte_valid && !full;
        collecting   = (state == ST_COLLECT);
        at_last_slot = (idx == LAST_IDX);
        complete     = accept && collecting && at_last_slot && byte_last;
        // Short (last before final slot) or long (final slot without last).
        drop         = accept && collecting && (byte_last != at_last_slot);
        do_pop       = pop && !empty;
        // The completing byte lands in the FIFO at the same edge, so it is
        // spliced in here rather than read back from asm_msg.
        wr_data      = {asm_msg[MSG_BITS-1:8], byte_data};
    end

    assign byte_ready       = !full;
    assign buffer_not_empty = !empty;
    assign ff_buffer        = mem[rd_ptr[AW-1:0]];

    // Assembler control
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_COLLECT;
            idx   <= '0;
        end else if (accept) begin
            if (state == ST_DISCARD) begin
                if (byte_last)
                    state <= ST_COLLECT;
            end else if (byte_last || at_last_slot) begin
                idx <= '0;
                if (!byte_last)
                    state <= ST_DISCARD;
            end else begin
                idx <= idx + IDX_ONE;
            end
        end
    end

    // Message assembly and FIFO storage (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (accept && collecting) begin
            for (int unsigned i = 0; i < MSG_BYTES; i++) begin
                if (idx == IW'(i))
                    asm_msg[(MSG_BYTES-1-i)*8 +: 8] <= byte_data;
            end
        end
        if (complete)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (complete)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Error reporting
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            len_err    <= 1'b0;
            drop_count <= '0;
        end else begin
            len_err <= drop;
            if (drop && (drop_count != '1))
                drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_order_msg_buffer.sv
`timescale 1ns/1ps
module tb_order_msg_buffer;

    localparam int DEPTH     = 4;
    localparam int MSG_BYTES = 40;
    localparam int MB        = MSG_BYTES * 8;

    logic          clk        = 1'b0;
    logic          resetn     = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data  = 8'h00;
    logic          byte_last  = 1'b0;
    logic          pop        = 1'b0;
    logic          byte_ready;
    logic          buffer_not_empty;
    logic [MB-1:0] ff_buffer;
    logic          len_err;
    logic [7:0]    drop_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    order_msg_buffer #(
        .DEPTH     (DEPTH),
        .MSG_BYTES (MSG_BYTES)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .byte_valid       (byte_valid),
        .byte_data        (byte_data),
        .byte_last        (byte_last),
        .byte_ready       (byte_ready),
        .pop              (pop),
        .buffer_not_empty (buffer_not_empty),
        .ff_buffer        (ff_buffer),
        .len_err          (len_err),
        .drop_count       (drop_count)
    );

    task automatic chk(input string name, input logic [MB-1:0] act, input logic [MB-1:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]    m_cur[$];
    logic [MB-1:0] m_q[$];
    bit            m_discard;
    int            m_drop;
    bit            m_len;

    initial begin : model
        bit            acc;
        bit            popk;
        bit            dropped;
        bit            have;
        logic [MB-1:0] done;
        m_discard = 0;
        m_drop    = 0;
        m_len     = 0;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_cur.delete();
                m_q.delete();
                m_discard = 0;
                m_drop    = 0;
                m_len     = 0;
            end else begin
                acc     = byte_valid && (m_q.size() < DEPTH);
                popk    = pop && (m_q.size() > 0);
                dropped = 0;
                have    = 0;
                done    = '0;
                if (acc) begin
                    if (m_discard) begin
                        if (byte_last)
                            m_discard = 0;
                    end else begin
                        m_cur.push_back(byte_data);
                        if (m_cur.size() == MSG_BYTES) begin
                            if (byte_last) begin
                                for (int i = 0; i < MSG_BYTES; i++)
                                    done[(MSG_BYTES-1-i)*8 +: 8] = m_cur[i];
                                have = 1;
                            end else begin
                                dropped   = 1;
                                m_discard = 1;
                            end
                            m_cur.delete();
                        end else if (byte_last) begin
                            dropped = 1;
                            m_cur.delete();
                        end
                    end
                end
                if (popk)
                    void'(m_q.pop_front());
                if (have)
                    m_q.push_back(done);
                m_len = dropped;
                if (dropped && m_drop < 255)
                    m_drop++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (resetn) begin
            chk("byte_ready", byte_ready, (m_q.size() < DEPTH));
            chk("buffer_not_empty", buffer_not_empty, (m_q.size() > 0));
            chk("len_err", len_err, m_len);
            chk("drop_count", drop_count, m_drop[7:0]);
            if (m_q.size() > 0)
                chk("ff_buffer", ff_buffer, m_q[0]);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [MB-1:0] make_msg(input logic [7:0] seed);
        logic [MB-1:0] m;
        for (int i = 0; i < MSG_BYTES; i++)
            m[(MSG_BYTES-1-i)*8 +: 8] = seed + 8'(i);
        return m;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic last);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = last;
        while (!byte_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!byte_ready) begin
            chk("ready_timeout", 1'b0, 1'b1);
            byte_valid = 1'b0;
            byte_last  = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic send_msg(input logic [MB-1:0] m, input bit pop_last);
        for (int i = 0; i < MSG_BYTES; i++) begin
            if (i == MSG_BYTES - 1 && pop_last)
                pop = 1'b1;
            send_byte(m[(MSG_BYTES-1-i)*8 +: 8], (i == MSG_BYTES - 1));
        end
        pop = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        @(posedge clk);
        #1;
        pop = 1'b0;
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        pop        = 1'b0;
        resetn     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin : stim
        logic [MB-1:0] m;

        do_reset();
        chk("rst_not_empty", buffer_not_empty, 1'b0);
        chk("rst_ready", byte_ready, 1'b1);
        chk("rst_len_err", len_err, 1'b0);
        chk("rst_drop", drop_count, 8'd0);

        // single message 0x53, 0x01..0x27
        m = make_msg(8'h00);
        m[MB-1 -: 8] = 8'h53;
        for (int i = 0; i < MSG_BYTES - 1; i++)
            send_byte(m[(MSG_BYTES-1-i)*8 +: 8], 1'b0);
        chk("single_before_last", buffer_not_empty, 1'b0);
        send_byte(m[7:0], 1'b1);
        chk("single_not_empty", buffer_not_empty, 1'b1);
        chk("single_byte0", ff_buffer[MB-1 -: 8], 8'h53);
        chk("single_byte39", ff_buffer[7:0], 8'h27);
        do_pop();
        chk("single_popped", buffer_not_empty, 1'b0);
        do_pop();
        chk("pop_empty_ne", buffer_not_empty, 1'b0);
        chk("pop_empty_err", len_err, 1'b0);
        chk("pop_empty_ready", byte_ready, 1'b1);

        // fill to full, stall, pop once
        do_reset();
        for (int k = 1; k <= 4; k++)
            send_msg(make_msg(8'(k * 16)), 1'b0);
        chk("full_ready", byte_ready, 1'b0);
        chk("full_head", ff_buffer[MB-1 -: 8], 8'h10);
        byte_valid = 1'b1;
        byte_data  = 8'h99;
        repeat (3) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        do_pop();
        chk("pop_ready", byte_ready, 1'b1);
        chk("pop_head", ff_buffer[MB-1 -: 8], 8'h20);
        send_msg(make_msg(8'h50), 1'b0);
        chk("refull_ready", byte_ready, 1'b0);
        repeat (4) do_pop();
        chk("drained", buffer_not_empty, 1'b0);

        // short message
        do_reset();
        for (int i = 1; i <= 10; i++)
            send_byte(8'(i), (i == 10));
        chk("short_len_err", len_err, 1'b1);
        chk("short_drop", drop_count, 8'd1);
        @(posedge clk);
        #1;
        chk("short_pulse_end", len_err, 1'b0);
        send_msg(make_msg(8'h40), 1'b0);
        chk("short_next_head", ff_buffer, make_msg(8'h40));
        chk("short_drop_hold", drop_count, 8'd1);

        // long message
        do_reset();
        for (int i = 0; i < 45; i++) begin
            send_byte(8'(i + 1), (i == 44));
            if (i == 39) begin
                chk("long_len_err", len_err, 1'b1);
                chk("long_drop", drop_count, 8'd1);
            end else if (i > 39) begin
                chk("long_no_err", len_err, 1'b0);
            end
        end
        chk("long_empty", buffer_not_empty, 1'b0);
        send_msg(make_msg(8'h70), 1'b0);
        chk("long_next_byte0", ff_buffer[MB-1 -: 8], 8'h70);
        chk("long_drop_hold", drop_count, 8'd1);

        // simultaneous completion and pop at occupancy 2
        do_reset();
        send_msg(make_msg(8'hA0), 1'b0);
        send_msg(make_msg(8'hB0), 1'b0);
        send_msg(make_msg(8'hC0), 1'b1);
        chk("sim_head", ff_buffer, make_msg(8'hB0));
        do_pop();
        chk("sim_head2", ff_buffer[MB-1 -: 8], 8'hC0);
        do_pop();
        chk("sim_empty", buffer_not_empty, 1'b0);

        // partial message held across idle cycles
        do_reset();
        m = make_msg(8'h30);
        for (int i = 0; i < 15; i++)
            send_byte(m[(MSG_BYTES-1-i)*8 +: 8], 1'b0);
        repeat (10) @(posedge clk);
        #1;
        for (int i = 15; i < MSG_BYTES; i++)
            send_byte(m[(MSG_BYTES-1-i)*8 +: 8], (i == MSG_BYTES - 1));
        chk("hold_byte0", ff_buffer[MB-1 -: 8], 8'h30);
        chk("hold_byte39", ff_buffer[7:0], 8'h57);

        // reset mid-message, then a fresh message
        do_reset();
        m = make_msg(8'h11);
        for (int i = 0; i < 20; i++)
            send_byte(m[(MSG_BYTES-1-i)*8 +: 8], 1'b0);
        do_reset();
        chk("midrst_empty", buffer_not_empty, 1'b0);
        send_msg(make_msg(8'hE0), 1'b0);
        chk("midrst_byte0", ff_buffer[MB-1 -: 8], 8'hE0);
        chk("midrst_byte39", ff_buffer[7:0], 8'h07);
        do_pop();
        chk("midrst_one_msg", buffer_not_empty, 1'b0);

        // drop_count saturation
        do_reset();
        for (int i = 0; i < 260; i++)
            send_byte(8'h5A, 1'b1);
        chk("sat_drop", drop_count, 8'd255);
        chk("sat_len_err", len_err, 1'b1);
        @(posedge clk);
        #1;
        chk("sat_len_err_end", len_err, 1'b0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/order_msg_buffer.md
ORDER_MSG_BUFFER -- requirements
Module: order_msg_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of 320-bit message slots (power of two, 2..16).
REQ-002 Parameter: MSG_BYTES, default 40, bytes per order message (fixed so that MSG_BYTES*8 = 320).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 byte_valid  input  1  a feed byte is presented on byte_data.
REQ-006 byte_data  input  8  feed byte; the first byte of a message is the most significant.
REQ-007 byte_last  input  1  the presented byte is the final byte of a message.
REQ-008 byte_ready  output  1  the block accepts a byte this cycle; a transfer occurs when byte_valid and byte_ready are both high.
REQ-009 pop  input  1  the downstream parser consumes the head message.
REQ-010 buffer_not_empty  output  1  at least one complete message is stored.
REQ-011 ff_buffer  output  320  the head message; byte 0 is in [319:312] and byte 39 is in [7:0].
REQ-012 len_err  output  1  one-cycle pulse when a malformed message is dropped.
REQ-013 drop_count  output  8  saturating count of dropped messages.

Function
REQ-014 Assembler states:
- COLLECT: index 0..MSG_BYTES-1.
- DISCARD: waits for the end of the message.
REQ-015 In COLLECT, each accepted byte SHALL be written to byte slot index, and the index SHALL increment.
REQ-016 A byte accepted in COLLECT with index = MSG_BYTES-1 and byte_last = 1 SHALL complete the message:
- the message is written into the FIFO at that same edge;
- the index returns to 0.
REQ-017 A byte accepted in COLLECT with byte_last = 1 and index < MSG_BYTES-1 (short message) SHALL be handled as follows:
- the partial message is discarded;
- len_err pulses for 1 cycle;
- drop_count increments;
- the index returns to 0;
- the state stays COLLECT.
REQ-018 A byte accepted in COLLECT with index = MSG_BYTES-1 and byte_last = 0 (long message) SHALL be handled as follows:
- the message is discarded;
- len_err pulses;
- drop_count increments;
- the state moves to DISCARD.
REQ-019 In DISCARD, accepted bytes SHALL be dropped; an accepted byte with byte_last = 1 SHALL return the state to COLLECT with index 0, with no further len_err.
REQ-020 byte_ready SHALL be the registered-free expression NOT(FIFO full); bytes are never accepted while the FIFO is full, in any state.
REQ-021 The FIFO SHALL be first-word-fall-through:
- ff_buffer always shows the oldest stored message;
- ff_buffer is don't-care while empty.
REQ-022 Latency: a completing byte accepted at edge N SHALL make buffer_not_empty = 1 and ff_buffer valid from edge N onward, when the FIFO was empty before edge N.
REQ-023 pop with buffer_not_empty = 1 SHALL remove the head at the edge; pop while empty SHALL be ignored and cause no error.
REQ-024 A simultaneous completion and pop on a non-empty FIFO SHALL leave the occupancy unchanged and advance the head.
REQ-025 Occupancy SHALL be tracked by read/write pointers with a wrap bit, so that full and empty are distinguished when the pointers are equal.
REQ-026 drop_count SHALL saturate at 255.
REQ-027 byte_valid = 0 SHALL hold all assembler state, including a partial message, indefinitely.

Reset
REQ-028 While resetn = 0, the block SHALL asynchronously clear:
- the FIFO pointers and occupancy;
- the index, with state set to COLLECT;
- len_err and drop_count.
REQ-029 Immediately after reset: buffer_not_empty = 0, byte_ready = 1, len_err = 0, drop_count = 0; ff_buffer content is not reset.
REQ-030 Reset mid-message or mid-DISCARD SHALL abandon the partial message; the first byte accepted after release is byte 0 of a new message.

Verification
REQ-031 Single message: 40 bytes 0x53,0x01..0x27, with last on byte 40 -> buffer_not_empty = 1 after the 40th edge; ff_buffer[319:312] = 0x53; ff_buffer[7:0] = 0x27.
REQ-032 Fill to full: 4 messages with no pop -> byte_ready = 0. Then pop once -> byte_ready = 1 next cycle, and the head becomes message 2.
REQ-033 Short message: byte_last on byte 10 -> len_err pulses once; drop_count = 1; the next 40-byte message is stored intact.
REQ-034 Long message: 45 bytes with last on byte 45 -> len_err pulses at byte 40; drop_count = 1; the FIFO stays empty; the next message is stored.
REQ-035 Simultaneous completion and pop with occupancy 2 -> occupancy stays 2; the head advances; no data corruption.
REQ-036 Reset after byte 20 of a message, then a fresh 40-byte message -> exactly 1 message is stored, equal to the fresh bytes.
